decode_queue: RTL and testbench

//  Parametrised decode stage between fetch and execute: accepts raw RV64I words + PC over valid/ready,

---
 rtl/decode_queue.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decode stage between fetch and execute: decodes RV64I words on enqueue into a
// DEPTH-entry FIFO of micro-ops and issues them in order.
module decode_queue #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ALU_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_ra1,
    output logic [4:0]       out_ra2,
    output logic [XLEN-1:0]  out_imm,
    output logic [ALU_W-1:0] out_alufunc,
    output logic             out_regwrite,
    output logic             out_memread,
    output logic             out_memwrite,
    output logic             out_branch,
    output logic             out_nop,
    output logic             out_illegal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_CMPEQ = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_LINK  = ALU_W'(6);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [4:0]       rd;
        logic [4:0]       ra1;
        logic [4:0]       ra2;
        logic [XLEN-1:0]  imm;
        logic [ALU_W-1:0] alufunc;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             branch;
        logic             nop;
        logic             illegal;
    } uop_t;

    uop_t             mem [DEPTH];
    uop_t             dec;
    uop_t             head;
    logic             legal;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rd_f;
    logic [4:0]       rs1_f;
    logic [4:0]       rs2_f;
    logic [XLEN-1:0]  imm_i;
    logic [XLEN-1:0]  imm_s;
    logic [XLEN-1:0]  imm_b;
    logic [XLEN-1:0]  imm_u;
    logic [XLEN-1:0]  imm_j;

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign opcode = in_instr[6:0];
    assign rd_f   = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign f7     = in_instr[31:25];

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'h000};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // Decode of the incoming word; unrecognised encodings collapse to an illegal bubble.
    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.pc = in_pc;
        case (opcode)
            OP_IMM: begin
                legal        = 1'b1;
                dec.rd       = rd_f;
                dec.ra1      = rs1_f;
                dec.imm      = imm_i;
                dec.regwrite = 1'b1;
                case (f3)
                    3'b000:  dec.alufunc = ALU_ADD;
                    3'b100:  dec.alufunc = ALU_XOR;
                    3'b110:  dec.alufunc = ALU_OR;
                    3'b111:  dec.alufunc = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OP_REG: begin
                legal        = 1'b1;
                dec.rd       = rd_f;
                dec.ra1      = rs1_f;
                dec.ra2      = rs2_f;
                dec.regwrite = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: dec.alufunc = ALU_ADD;
                    10'b0100000_000: dec.alufunc = ALU_SUB;
                    10'b0000000_100: dec.alufunc = ALU_XOR;
                    10'b0000000_110: dec.alufunc = ALU_OR;
                    10'b0000000_111: dec.alufunc = ALU_AND;
                    default:         legal = 1'b0;
                endcase
            end
            OP_LUI, OP_AUIPC: begin
                legal        = 1'b1;
                dec.rd       = rd_f;
                dec.imm      = imm_u;
                dec.regwrite = 1'b1;
            end
            OP_LOAD: begin
                legal        = (f3 == 3'b011);
                dec.rd       = rd_f;
                dec.ra1      = rs1_f;
                dec.imm      = imm_i;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            OP_STORE: begin
                legal        = (f3 == 3'b011);
                dec.ra1      = rs1_f;
                dec.ra2      = rs2_f;
                dec.imm      = imm_s;
                dec.memwrite = 1'b1;
            end
            OP_BRANCH: begin
                legal       = (f3 == 3'b000);
                dec.ra1     = rs1_f;
                dec.ra2     = rs2_f;
                dec.imm     = imm_b;
                dec.alufunc = ALU_CMPEQ;
                dec.branch  = 1'b1;
            end
            OP_JAL: begin
                legal        = 1'b1;
                dec.rd       = rd_f;
                dec.imm      = imm_j;
                dec.alufunc  = ALU_LINK;
                dec.branch   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_JALR: begin
                legal        = (f3 == 3'b000);
                dec.rd       = rd_f;
                dec.ra1      = rs1_f;
                dec.imm      = imm_i;
                dec.alufunc  = ALU_LINK;
                dec.branch   = 1'b1;
                dec.regwrite = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
        dec.nop = (in_instr == 32'h0000_0013);
    end

    // Occupancy and pointers; reset dominates flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is not cleared; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= dec;
    end

    assign head         = mem[rd_ptr];
    assign out_pc       = head.pc;
    assign out_rd       = head.rd;
    assign out_ra1      = head.ra1;
    assign out_ra2      = head.ra2;
    assign out_imm      = head.imm;
    assign out_alufunc  = head.alufunc;
    assign out_regwrite = head.regwrite;
    assign out_memread  = head.memread;
    assign out_memwrite = head.memwrite;
    assign out_branch   = head.branch;
    assign out_nop      = head.nop;
    assign out_illegal  = head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed head values.
module tb_decode_queue;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ALU_W = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       out_rd;
    logic [4:0]       out_ra1;
    logic [4:0]       out_ra2;
    logic [XLEN-1:0]  out_imm;
    logic [ALU_W-1:0] out_alufunc;
    logic             out_regwrite;
    logic             out_memread;
    logic             out_memwrite;
    logic             out_branch;
    logic             out_nop;
    logic             out_illegal;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ALU_W(ALU_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_ra1(out_ra1), .out_ra2(out_ra2), .out_imm(out_imm),
        .out_alufunc(out_alufunc), .out_regwrite(out_regwrite), .out_memread(out_memread),
        .out_memwrite(out_memwrite), .out_branch(out_branch), .out_nop(out_nop),
        .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [3:0]  alu;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic        nop;
        logic        illegal;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;
    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules.
    function automatic exp_t model_decode(input logic [31:0] w, input logic [63:0] pc);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        longint      ii, is, ib, iu, ij;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        ii = $signed(w[31:20]);
        is = $signed({w[31:25], w[11:7]});
        ib = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        iu = $signed({w[31:12], 12'h000});
        ij = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        e = '0;
        e.pc = pc;
        if (op == 7'h13 && (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)) begin
            e.rd = w[11:7]; e.ra1 = w[19:15]; e.imm = ii; e.regwrite = 1;
            e.alu = (f3 == 0) ? 4'd0 : (f3 == 4) ? 4'd4 : (f3 == 6) ? 4'd3 : 4'd2;
        end else if (op == 7'h33 && f7 == 0 && (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)) begin
            e.rd = w[11:7]; e.ra1 = w[19:15]; e.ra2 = w[24:20]; e.regwrite = 1;
            e.alu = (f3 == 0) ? 4'd0 : (f3 == 4) ? 4'd4 : (f3 == 6) ? 4'd3 : 4'd2;
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 0) begin
            e.rd = w[11:7]; e.ra1 = w[19:15]; e.ra2 = w[24:20]; e.regwrite = 1; e.alu = 4'd1;
        end else if (op == 7'h37 || op == 7'h17) begin
            e.rd = w[11:7]; e.imm = iu; e.regwrite = 1;
        end else if (op == 7'h03 && f3 == 3) begin
            e.rd = w[11:7]; e.ra1 = w[19:15]; e.imm = ii; e.regwrite = 1; e.memread = 1;
        end else if (op == 7'h23 && f3 == 3) begin
            e.ra1 = w[19:15]; e.ra2 = w[24:20]; e.imm = is; e.memwrite = 1;
        end else if (op == 7'h63 && f3 == 0) begin
            e.ra1 = w[19:15]; e.ra2 = w[24:20]; e.imm = ib; e.branch = 1; e.alu = 4'd5;
        end else if (op == 7'h6F) begin
            e.rd = w[11:7]; e.imm = ij; e.regwrite = 1; e.branch = 1; e.alu = 4'd6;
        end else if (op == 7'h67 && f3 == 0) begin
            e.rd = w[11:7]; e.ra1 = w[19:15]; e.imm = ii; e.regwrite = 1; e.branch = 1; e.alu = 4'd6;
        end else begin
            e.illegal = 1;
        end
        e.nop = (w == 32'h0000_0013);
        return e;
    endfunction

    // Model occupancy follows the handshake rules using its own fill level.
    always @(posedge clk) begin
        if (reset || flush) begin
            q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model_decode(in_instr, in_pc));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            if (q.size() != 0) begin
                chk("pc", out_pc, q[0].pc);
                chk("imm", out_imm, q[0].imm);
                chk("rd", 64'(out_rd), 64'(q[0].rd));
                chk("ra1", 64'(out_ra1), 64'(q[0].ra1));
                chk("ra2", 64'(out_ra2), 64'(q[0].ra2));
                chk("alufunc", 64'(out_alufunc), 64'(q[0].alu));
                chk("flags", 64'({out_regwrite, out_memread, out_memwrite, out_branch, out_nop, out_illegal}),
                    64'({q[0].regwrite, q[0].memread, q[0].memwrite, q[0].branch, q[0].nop, q[0].illegal}));
            end
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] i;
        i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'd3, i[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] i;
        i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'h6F};
    endfunction

    // Offer a word until accepted (bounded), then drop in_valid.
    task automatic send(input logic [31:0] w, input logic [63:0] pc);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        do begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 20);
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] stream [14];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Single ADDI x1, x0, 5 straight through.
        out_ready = 1'b1;
        send(32'h0050_0093, 64'h8000_0000);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_rd", 64'(out_rd), 64'd1);
        chk("t1_ra1", 64'(out_ra1), 64'd0);
        chk("t1_imm", out_imm, 64'd5);
        chk("t1_alu", 64'(out_alufunc), 64'd0);
        chk("t1_regwrite", 64'(out_regwrite), 64'd1);
        chk("t1_pc", out_pc, 64'h8000_0000);
        @(negedge clk);
        chk("t1_empty", 64'(out_valid), 64'd0);

        // SUB then BEQ.
        out_ready = 1'b0;
        send(32'h4020_81B3, 64'h8000_0004);
        send(32'hFE20_8CE3, 64'h8000_0008);
        chk("t2_sub_rd", 64'(out_rd), 64'd3);
        chk("t2_sub_ra1", 64'(out_ra1), 64'd1);
        chk("t2_sub_ra2", 64'(out_ra2), 64'd2);
        chk("t2_sub_alu", 64'(out_alufunc), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t2_beq_branch", 64'(out_branch), 64'd1);
        chk("t2_beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("t2_beq_rd", 64'(out_rd), 64'd0);
        chk("t2_beq_alu", 64'(out_alufunc), 64'd5);
        @(negedge clk);

        // Fill to DEPTH, hold a fifth word, then pop-only on a full queue.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_instr = enc_i(k, 0, 0, k, 7'h13);
            in_pc    = 64'h100 + 64'(4 * k);
            @(negedge clk);
        end
        chk("t3_full_ready", 64'(in_ready), 64'd0);
        in_instr = enc_i(5, 0, 0, 5, 7'h13);
        in_pc    = 64'h114;
        @(negedge clk);
        chk("t3_held_ready", 64'(in_ready), 64'd0);
        chk("t3_head1", 64'(out_rd), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_ready_after_pop", 64'(in_ready), 64'd1);
        chk("t4_head2", 64'(out_rd), 64'd2);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            chk("t3_order", 64'(out_rd), 64'(k));
            @(negedge clk);
        end
        chk("t3_drained", 64'(out_valid), 64'd0);

        // Flush with three queued and a word offered.
        out_ready = 1'b0;
        for (int k = 6; k <= 8; k++) send(enc_r(0, 2, 1, 0, k), 64'h200 + 64'(k));
        flush = 1'b1; in_valid = 1'b1; in_instr = enc_r(0, 3, 4, 0, 9);
        @(negedge clk);
        chk("t5_flush_valid", 64'(out_valid), 64'd0);
        chk("t5_flush_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_dropped", 64'(out_valid), 64'd0);

        // Illegal, canonical NOP, then reset (with flush) mid-stream.
        send(32'hFFFF_FFFF, 64'h300);
        chk("t6_illegal", 64'(out_illegal), 64'd1);
        chk("t6_ill_writes", 64'({out_regwrite, out_memread, out_memwrite, out_branch}), 64'd0);
        chk("t6_ill_regs", 64'({out_rd, out_ra1, out_ra2}), 64'd0);
        chk("t6_ill_imm", out_imm, 64'd0);
        send(32'h0000_0013, 64'h304);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_nop", 64'(out_nop), 64'd1);
        chk("t6_nop_legal", 64'(out_illegal), 64'd0);
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h0050_0093, 64'h308);
        send(32'h4020_81B3, 64'h30C);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("t6_reset_valid", 64'(out_valid), 64'd0);
        chk("t6_reset_ready", 64'(in_ready), 64'd1);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_after_reset", 64'(out_valid), 64'd0);

        // Mixed instruction stream under intermittent backpressure.
        stream[0]  = enc_i(-16, 7, 3, 10, 7'h03);
        stream[1]  = enc_s(40, 11, 2);
        stream[2]  = {20'hFFFFF, 5'd5, 7'h37};
        stream[3]  = {20'h12345, 5'd6, 7'h17};
        stream[4]  = enc_j(-2048, 1);
        stream[5]  = enc_i(8, 5, 0, 1, 7'h67);
        stream[6]  = enc_i(-1, 3, 6, 4, 7'h13);
        stream[7]  = enc_i(255, 3, 7, 4, 7'h13);
        stream[8]  = enc_i(-2048, 3, 4, 4, 7'h13);
        stream[9]  = enc_r(0, 9, 8, 6, 7);
        stream[10] = enc_r(0, 9, 8, 7, 7);
        stream[11] = enc_r(0, 9, 8, 4, 7);
        stream[12] = enc_i(3, 1, 1, 2, 7'h13);
        stream[13] = enc_r(32, 9, 8, 1, 7);
        for (int i = 0; i < 14; i++) begin
            out_ready = (i % 3) != 0;
            send(stream[i], 64'h1000 + 64'(4 * i));
        end
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t7_drained", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
